// File: rtl/adc_frame_align_if.sv
`default_nettype none
// ============================================================================
// Module  : adc_frame_align_if
// Brief   : Frame word, control and status bundle of the frame aligner.
// Revision: 1.0 - initial release
// ============================================================================
interface adc_frame_align_if #(
   parameter int FW = 6,
   parameter int CW = 16
);
   logic [FW-1:0] FR;
   logic          enable;
   logic          realign;
   logic          cnt_rst;
   logic          BS;
   logic          locked;
   logic          fail;
   logic [2:0]    state;
   logic [CW-1:0] slip_cnt;
   logic [CW-1:0] lost_cnt;

   modport master (
      output FR, enable, realign, cnt_rst,
      input  BS, locked, fail, state, slip_cnt, lost_cnt
   );

   modport slave (
      input  FR, enable, realign, cnt_rst,
      output BS, locked, fail, state, slip_cnt, lost_cnt
   );
endinterface
`default_nettype wire

// File: rtl/adc_frame_align.sv
`default_nettype none
// ============================================================================
// Module  : adc_frame_align
// Brief   : Closed-loop ISERDES frame aligner: bitslips until the frame word
//           matches, holds lock, realigns on loss, keeps slip/loss statistics.
// Revision: 1.0 - initial release
// ============================================================================
module adc_frame_align #(
   parameter int            FW        = 6,
   parameter logic [FW-1:0] FPAT      = 6'b111000,
   parameter int            SLIP_WAIT = 4,
   parameter int            LOCK_CNT  = 16,
   parameter int            MAX_SLIPS = 12,
   parameter int            CW        = 16
) (
   input wire logic          CLK,
   input wire logic          reset,
   adc_frame_align_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CHECK  = 3'd1,
      S_SLIP   = 3'd2,
      S_WAIT   = 3'd3,
      S_LOCKED = 3'd4,
      S_FAIL   = 3'd5
   } state_t;

   localparam int c_MW = $clog2(LOCK_CNT + 1);
   localparam int c_AW = (MAX_SLIPS < 1) ? 1 : $clog2(MAX_SLIPS + 1);
   localparam int c_WW = $clog2(SLIP_WAIT + 1);

   localparam logic [c_MW-1:0] c_LOCK_LAST = c_MW'(LOCK_CNT - 1);
   localparam logic [c_AW-1:0] c_MAX_SLIPS = c_AW'(MAX_SLIPS);
   localparam logic [c_WW-1:0] c_WAIT_LOAD = c_WW'(SLIP_WAIT - 1);
   localparam logic [CW-1:0]   c_SAT       = '1;

   state_t          r_state;
   logic [c_MW-1:0] r_match;
   logic [c_AW-1:0] r_att;
   logic [c_WW-1:0] r_wait;
   logic            r_bs;
   logic            r_locked;
   logic            r_fail;
   logic [CW-1:0]   r_slip_cnt;
   logic [CW-1:0]   r_lost_cnt;

   logic            w_match;
   logic            w_loss;

   assign w_match = (bus.FR == FPAT);
   // Only a genuine mismatch while locked counts as a loss; enable/realign win.
   assign w_loss  = (r_state == S_LOCKED) && bus.enable && !bus.realign && !w_match;

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_match  <= '0;
         r_att    <= '0;
         r_wait   <= '0;
         r_bs     <= 1'b0;
         r_locked <= 1'b0;
         r_fail   <= 1'b0;
      end else begin
         // Status flags are rebuilt each cycle from the state being entered.
         r_bs     <= 1'b0;
         r_locked <= 1'b0;
         r_fail   <= 1'b0;
         if (!bus.enable) begin
            r_state <= S_IDLE;
         end else if (bus.realign && (r_state != S_IDLE)) begin
            r_state <= S_CHECK;
            r_match <= '0;
            r_att   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_CHECK;
                  r_match <= '0;
                  r_att   <= '0;
               end
               S_CHECK: begin
                  if (w_match) begin
                     r_match <= r_match + 1'b1;
                     if (r_match == c_LOCK_LAST) begin
                        r_state  <= S_LOCKED;
                        r_locked <= 1'b1;
                     end
                  end else if (r_att < c_MAX_SLIPS) begin
                     r_state <= S_SLIP;
                     r_bs    <= 1'b1;
                     r_match <= '0;
                  end else begin
                     r_state <= S_FAIL;
                     r_fail  <= 1'b1;
                  end
               end
               S_SLIP: begin
                  r_att   <= r_att + 1'b1;
                  r_wait  <= c_WAIT_LOAD;
                  r_state <= S_WAIT;
               end
               S_WAIT: begin
                  if (r_wait == '0) begin
                     r_state <= S_CHECK;
                     r_match <= '0;
                  end else begin
                     r_wait <= r_wait - 1'b1;
                  end
               end
               S_LOCKED: begin
                  if (w_match) begin
                     r_locked <= 1'b1;
                  end else begin
                     r_state <= S_CHECK;
                     r_match <= '0;
                     r_att   <= '0;
                  end
               end
               S_FAIL: begin
                  r_fail <= 1'b1;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   // A pulse already issued is always counted, even if enable drops with it.
   always_ff @(posedge CLK) begin
      if (reset || bus.cnt_rst) begin
         r_slip_cnt <= '0;
         r_lost_cnt <= '0;
      end else begin
         if ((r_state == S_SLIP) && (r_slip_cnt != c_SAT)) begin
            r_slip_cnt <= r_slip_cnt + 1'b1;
         end
         if (w_loss && (r_lost_cnt != c_SAT)) begin
            r_lost_cnt <= r_lost_cnt + 1'b1;
         end
      end
   end

   assign bus.BS       = r_bs;
   assign bus.locked   = r_locked;
   assign bus.fail     = r_fail;
   assign bus.state    = r_state;
   assign bus.slip_cnt = r_slip_cnt;
   assign bus.lost_cnt = r_lost_cnt;

endmodule
`default_nettype wire
